// File: rtl/arm_pkg.sv
// Shared types for the MEM/WB slice: access FSM states,
// default data-memory base and the byte-to-word address map.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    COMPLETE
  } mem_state_e;

  localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;

  function automatic logic [31:0] map_addr(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory request sequencer: owns the mem_* registers and freeze.
// Build option MEM_ADDR_MAP_EN turns byte addresses into word indices.
module mem_access_fsm
  import arm_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_rm,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        freeze,
  output logic        complete,
  output logic        is_write,
  output logic [31:0] rdata_q
);

`ifdef MEM_ADDR_MAP_EN
  localparam bit MAP_EN = 1'b1;
`else
  localparam bit MAP_EN = 1'b0;
`endif

  mem_state_e  state;
  logic        access;
  logic        write;
  logic [31:0] addr_next;

  assign access = mem_r_en | mem_w_en;
  // a request with both enables is a read
  assign write  = mem_w_en & ~mem_r_en;

  assign addr_next = MAP_EN
                   ? map_addr(alu_result, ADDR_BASE)
                   : alu_result;

  assign freeze   = ((state == IDLE) & access)
                  | (state == ACCESS);
  assign complete = (state == COMPLETE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      is_write  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            state     <= ACCESS;
            mem_req   <= 1'b1;
            mem_we    <= write;
            mem_addr  <= addr_next;
            mem_wdata <= val_rm;
            is_write  <= write;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state   <= COMPLETE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            rdata_q <= mem_rdata;
          end
        end
        COMPLETE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: memory access sequencing plus the WB register.
// Build option MEM_ADDR_MAP_EN maps byte addresses to word indices.
module mem_wb_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic        exe_mem_w_en,
  input  logic [31:0] exe_alu_result,
  input  logic [31:0] exe_val_rm,
  input  logic [3:0]  exe_dest,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        freeze,
  output logic [3:0]  wb_dest,
  output logic [31:0] wb_value,
  output logic        wb_wb_en
);

  logic        complete;
  logic        is_write;
  logic [31:0] rdata_q;
  logic [31:0] wb_value_next;

  mem_access_fsm #(
    .ADDR_BASE (ADDR_BASE)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (exe_mem_r_en),
    .mem_w_en   (exe_mem_w_en),
    .alu_result (exe_alu_result),
    .val_rm     (exe_val_rm),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .freeze     (freeze),
    .complete   (complete),
    .is_write   (is_write),
    .rdata_q    (rdata_q)
  );

  assign wb_value_next = (complete & ~is_write)
                       ? rdata_q
                       : exe_alu_result;

  // frozen cycles insert a bubble; dest/value keep their last contents
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_dest  <= '0;
      wb_value <= '0;
      wb_wb_en <= 1'b0;
    end else if (freeze) begin
      wb_wb_en <= 1'b0;
    end else begin
      wb_dest  <= exe_dest;
      wb_value <= wb_value_next;
      wb_wb_en <= exe_wb_en & ~(complete & is_write);
    end
  end

endmodule
